// File: rtl/vgg_act_pkg.sv
// Shared types and sizing for the activation line buffer.
// Channel 0 of a pixel vector occupies the MSBs.
package vgg_act_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int CH         = 64;
    localparam int DW         = DATA_WIDTH * CH;
    localparam int MAX_W      = 224;
    localparam int AW         = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [AW-1:0] col_t;
    typedef logic [AW-1:0] row_t;

endpackage

// File: rtl/act_line_ram.sv
// One image row of pixel vectors; combinational read, so a read and a
// write to the same address in one cycle returns the old contents.
module act_line_ram
    import vgg_act_pkg::*;
#(
    parameter int DEPTH = MAX_W,
    parameter int WIDTH = DW
) (
    input  logic             clk,
    input  logic             i_we,
    input  col_t             i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  col_t             i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/act_line_buffer.sv
// Row-streaming line buffer emitting column-aligned (r-2, r-1, r) triplets.
// Define ACT_ZERO_PAD_EN for "same" padding of 1; default is "valid" mode.
module act_line_buffer
    import vgg_act_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] cfg_width,
    input  logic [AW-1:0] cfg_height,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          act_load,
    output logic [DW-1:0] data_first_row,
    output logic [DW-1:0] data_second_row,
    output logic [DW-1:0] data_third_row,
    output logic [AW-1:0] out_col,
    output logic          busy,
    output logic          frame_done
);

`ifdef ACT_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    // Padded mode starts emitting on row 1, valid mode on row 2
    localparam row_t FILL_LAST = PAD_EN ? row_t'(0) : row_t'(1);

    state_t r_state;
    state_t w_state_nx;
    col_t   r_col;
    col_t   w_col_nx;
    row_t   r_row;
    row_t   w_row_nx;
    col_t   r_w;
    row_t   r_h;

    logic          r_act_load;
    logic [DW-1:0] r_first;
    logic [DW-1:0] r_second;
    logic [DW-1:0] r_third;
    col_t          r_ocol;
    logic          r_frame_done;

    logic          w_in_ready;
    logic          w_acc;
    logic          w_in_last;
    logic          w_pos_lead;
    logic          w_pos_trail;
    logic          w_pos_px;
    logic          w_emit;
    col_t          w_ocol;
    col_t          w_addr;
    logic [DW-1:0] w_r0;
    logic [DW-1:0] w_r1;
    logic [DW-1:0] w_first;
    logic [DW-1:0] w_second;
    logic [DW-1:0] w_third;

    // In padded RUN/DRAIN, r_col is the output position 0..W+1
    assign w_pos_lead  = (r_col == '0);
    assign w_pos_trail = (r_col == r_w + 1'b1);
    assign w_pos_px    = !w_pos_lead && !w_pos_trail;
    assign w_in_last   = (r_col == r_w - 1'b1);

    assign w_in_ready = (r_state == FILL)
                     || ((r_state == RUN) && (!PAD_EN || w_pos_px));
    assign w_acc      = in_valid && w_in_ready;

    always_comb begin
        w_addr = r_col;
        if (PAD_EN && (r_state == RUN || r_state == DRAIN)) begin
            w_addr = w_pos_px ? r_col - 1'b1 : '0;
        end
    end

    act_line_ram u_ram0 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (w_addr),
        .i_wdata (w_r1),
        .i_raddr (w_addr),
        .o_rdata (w_r0)
    );

    act_line_ram u_ram1 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (w_addr),
        .i_wdata (in_data),
        .i_raddr (w_addr),
        .o_rdata (w_r1)
    );

    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        w_emit     = 1'b0;
        w_ocol     = r_col;
        w_first    = '0;
        w_second   = '0;
        w_third    = '0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_col_nx = '0;
                    w_row_nx = '0;
                    if (cfg_width == '0 || cfg_height == '0) begin
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = FILL;
                    end
                end
            end
            FILL: begin
                if (w_acc) begin
                    if (w_in_last) begin
                        w_col_nx = '0;
                        w_row_nx = r_row + 1'b1;
                        if (r_row == r_h - 1'b1) begin
                            w_state_nx = PAD_EN ? DRAIN : DONE;
                        end else if (r_row == FILL_LAST) begin
                            w_state_nx = RUN;
                        end
                    end else begin
                        w_col_nx = r_col + 1'b1;
                    end
                end
            end
            RUN: begin
                if (PAD_EN) begin
                    w_emit = w_acc || !w_pos_px;
                    if (w_acc) begin
                        w_first  = (r_row == row_t'(1)) ? '0 : w_r0;
                        w_second = w_r1;
                        w_third  = in_data;
                    end
                    if (w_pos_trail) begin
                        w_col_nx = '0;
                        w_row_nx = r_row + 1'b1;
                        if (r_row == r_h - 1'b1) begin
                            w_state_nx = DRAIN;
                        end
                    end else if (w_emit) begin
                        w_col_nx = r_col + 1'b1;
                    end
                end else begin
                    w_emit = w_acc;
                    if (w_acc) begin
                        w_first  = w_r0;
                        w_second = w_r1;
                        w_third  = in_data;
                        if (w_in_last) begin
                            w_col_nx = '0;
                            w_row_nx = r_row + 1'b1;
                            if (r_row == r_h - 1'b1) begin
                                w_state_nx = DONE;
                            end
                        end else begin
                            w_col_nx = r_col + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                // Last output row: stored rows only, bottom row is padding
                w_emit = 1'b1;
                if (w_pos_px) begin
                    w_first  = (r_h == row_t'(1)) ? '0 : w_r0;
                    w_second = w_r1;
                end
                if (w_pos_trail) begin
                    w_col_nx   = '0;
                    w_state_nx = DONE;
                end else begin
                    w_col_nx = r_col + 1'b1;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_act_load   <= 1'b0;
            r_first      <= '0;
            r_second     <= '0;
            r_third      <= '0;
            r_ocol       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_col        <= w_col_nx;
            r_row        <= w_row_nx;
            r_act_load   <= w_emit;
            r_frame_done <= (r_state == DONE);
            if (r_state == IDLE && start) begin
                r_w <= cfg_width;
                r_h <= cfg_height;
            end
            if (w_emit) begin
                r_first  <= w_first;
                r_second <= w_second;
                r_third  <= w_third;
                r_ocol   <= w_ocol;
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign act_load        = r_act_load;
    assign data_first_row  = r_first;
    assign data_second_row = r_second;
    assign data_third_row  = r_third;
    assign out_col         = r_ocol;
    assign busy            = (r_state != IDLE);
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_act_line_buffer.sv
// Randomised bench for act_line_buffer with a row/column triplet model.
// Builds for either padding mode (ACT_ZERO_PAD_EN).
`timescale 1ns/1ps
module tb_act_line_buffer;
    import vgg_act_pkg::*;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        int            col;
    } trip_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] cfg_width;
    logic [AW-1:0] cfg_height;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          act_load;
    logic [DW-1:0] data_first_row;
    logic [DW-1:0] data_second_row;
    logic [DW-1:0] data_third_row;
    logic [AW-1:0] out_col;
    logic          busy;
    logic          frame_done;

    int    checks = 0;
    int    errors = 0;
    trip_t exp_q[$];
    trip_t got_q[$];
    bit    fd_due = 0;
    bit    prev_acc = 0;
    bit    prev_rdy = 0;
    int    cur_w = 0;

    always #5 clk = ~clk;

    act_line_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .act_load        (act_load),
        .data_first_row  (data_first_row),
        .data_second_row (data_second_row),
        .data_third_row  (data_third_row),
        .out_col         (out_col),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    function automatic logic [DW-1:0] pix(int r, int c, int seed);
        logic [DW-1:0] v;
        for (int k = 0; k < CH; k++) begin
            v[DW-1-16*k -: 16] = 16'((r << 8) | c) + 16'(k * seed);
        end
        return v;
    endfunction

    task automatic chk_int(string nm, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_vec(string nm, logic [DW-1:0] got, logic [DW-1:0] exp);
        bit shown;
        checks++;
        shown = 0;
        if (got !== exp) begin
            errors++;
            for (int k = 0; k < CH; k++) begin
                if (!shown && got[DW-1-16*k -: 16] !== exp[DW-1-16*k -: 16]) begin
                    $display("FAIL %s: ch%0d got %h expected %h", nm, k,
                             got[DW-1-16*k -: 16], exp[DW-1-16*k -: 16]);
                    shown = 1;
                end
            end
        end
    endtask

    task automatic build_model(int w, int h, int seed);
        trip_t t;
        exp_q.delete();
`ifdef ACT_ZERO_PAD_EN
        for (int o = 0; o < h; o++) begin
            for (int k = 0; k < w + 2; k++) begin
                t.col = k;
                t.a = '0;
                t.b = '0;
                t.c = '0;
                if (k != 0 && k != w + 1) begin
                    if (o != 0) t.a = pix(o - 1, k - 1, seed);
                    t.b = pix(o, k - 1, seed);
                    if (o != h - 1) t.c = pix(o + 1, k - 1, seed);
                end
                exp_q.push_back(t);
            end
        end
`else
        for (int r = 2; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                t.col = c;
                t.a = pix(r - 2, c, seed);
                t.b = pix(r - 1, c, seed);
                t.c = pix(r, c, seed);
                exp_q.push_back(t);
            end
        end
`endif
    endtask

    always @(negedge clk) begin
        trip_t e;
        trip_t g;
        if (rst_n) begin
            if (fd_due) begin
                chk_int("frame_done_after_last", frame_done, 1);
                fd_due = 0;
            end
            if (act_load) begin
                g.a = data_first_row;
                g.b = data_second_row;
                g.c = data_third_row;
                g.col = out_col;
                got_q.push_back(g);
                chk_int("act_load_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_vec("first_row", data_first_row, e.a);
                    chk_vec("second_row", data_second_row, e.b);
                    chk_vec("third_row", data_third_row, e.c);
                    chk_int("out_col", out_col, e.col);
                    if (exp_q.size() == 0) fd_due = 1;
                end
`ifdef ACT_ZERO_PAD_EN
                if (out_col == 0 || out_col == cur_w + 1)
                    chk_int("pad_col_in_ready_low", prev_rdy, 0);
`else
                chk_int("act_load_after_accept", prev_acc, 1);
`endif
            end else if (frame_done) begin
                chk_int("frame_done_pending", exp_q.size(), 0);
            end
        end
        prev_acc = in_valid && in_ready;
        prev_rdy = in_ready;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        fd_due = 0;
        @(negedge clk);
        chk_int("rst_busy", busy, 0);
        chk_int("rst_act_load", act_load, 0);
        chk_int("rst_in_ready", in_ready, 0);
        chk_int("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(int w, int h, int seed, int gap, int abort_at, bit poke);
        int n;
        bit ok;
        build_model(w, h, seed);
        got_q.delete();
        cur_w = w;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_width = AW'(w);
        cfg_height = AW'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_int("busy_after_start", busy, 1);
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                in_data = pix(r, c, seed);
                ok = 0;
                for (int t = 0; t < 64 && !ok; t++) begin
                    in_valid = ($urandom_range(99) >= gap);
                    if (poke && n == 3 && t == 0) begin
                        start = 1'b1;
                        cfg_width = 1;
                        cfg_height = 1;
                    end
                    @(negedge clk);
                    ok = in_valid && in_ready;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    cfg_width = AW'(w);
                    cfg_height = AW'(h);
                end
                if (!ok) begin
                    chk_int("pixel_accepted", ok, 1);
                    in_valid = 1'b0;
                    do_reset();
                    return;
                end
                n++;
                if (n == abort_at) begin
                    do_reset();
                    return;
                end
            end
        end
        in_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 4 * w + 40 && !ok; t++) begin
            @(negedge clk);
            ok = frame_done;
        end
        chk_int("frame_done_seen", ok, 1);
        chk_int("pending_triplets", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic zero_cfg(int w, int h);
        bit ok;
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_width = AW'(w);
        cfg_height = AW'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
        ok = 0;
        for (int t = 0; t < 4 && !ok; t++) begin
            @(negedge clk);
            ok = frame_done;
        end
        chk_int("zero_cfg_frame_done", ok, 1);
        repeat (2) @(posedge clk);
        #1;
        chk_int("zero_cfg_no_act_load", got_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_int("reset_busy", busy, 0);
        chk_int("reset_act_load", act_load, 0);
        chk_int("reset_in_ready", in_ready, 0);
        chk_int("reset_frame_done", frame_done, 0);
        chk_int("reset_out_col", out_col, 0);
        chk_vec("reset_first_row", data_first_row, '0);

`ifdef ACT_ZERO_PAD_EN
        run_frame(3, 3, 0, 0, -1, 0);
        chk_int("pad_pulses", got_q.size(), 15);
        chk_vec("pad_r0c0_first", got_q[0].a, '0);
        chk_vec("pad_r0c0_third", got_q[0].c, '0);
        chk_int("pad_r0c1_first", got_q[1].a[15:0], 0);
        chk_int("pad_r0c1_second", got_q[1].b[15:0], 'h000);
        chk_int("pad_r0c1_third", got_q[1].c[15:0], 'h100);
        chk_int("pad_r2c3_first", got_q[13].a[15:0], 'h102);
        chk_int("pad_r2c3_second", got_q[13].b[15:0], 'h202);
        chk_int("pad_r2c3_third", got_q[13].c[15:0], 0);
`else
        run_frame(4, 4, 0, 0, -1, 0);
        chk_int("valid_pulses", got_q.size(), 8);
        chk_int("first_trip_a", got_q[0].a[15:0], 'h000);
        chk_int("first_trip_b", got_q[0].b[15:0], 'h100);
        chk_int("first_trip_c", got_q[0].c[15:0], 'h200);
        chk_int("last_trip_a", got_q[7].a[15:0], 'h103);
        chk_int("last_trip_b", got_q[7].b[15:0], 'h203);
        chk_int("last_trip_c", got_q[7].c[15:0], 'h303);
        chk_int("last_trip_col", got_q[7].col, 3);
`endif
        run_frame(4, 4, 0, 40, -1, 0);
        run_frame(4, 4, 5, 0, 6, 0);
        run_frame(4, 4, 7, 20, -1, 0);
        run_frame(5, 4, 3, 10, -1, 1);
        zero_cfg(4, 0);
        zero_cfg(0, 3);
        run_frame(3, 1, 9, 0, -1, 0);
        run_frame(3, 2, 9, 25, -1, 0);
        run_frame(MAX_W, 3, 11, 0, -1, 0);
        for (int i = 0; i < 8; i++) begin
            run_frame($urandom_range(12, 1), $urandom_range(6, 1),
                      $urandom_range(999, 1), $urandom_range(50, 0), -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
